// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin I/D-cache arbiter onto one memory line port (clk, proc_reset, i_mem_*/d_mem_* cache ports, mem_* memory port)
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_nx;
  logic owner, last, wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, resp;
  logic req_i, req_d, grant_d, busy, resp_st;
  assign req_i = i_mem_read | i_mem_write;
  assign req_d = d_mem_read | d_mem_write;
  assign grant_d = req_d & (~req_i | ~last);
  always_comb begin
    state_nx = state == IDLE ? ((req_i | req_d) ? BUSY : IDLE) :
               state == BUSY ? (mem_ready ? RESP : BUSY) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b0;
      wr    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      resp  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && (req_i | req_d)) begin
        owner <= grant_d;
        wr    <= grant_d ? d_mem_write : i_mem_write;
        addr  <= grant_d ? d_mem_addr : i_mem_addr;
        wdata <= grant_d ? d_mem_wdata : i_mem_wdata;
      end
      if (state == BUSY && mem_ready) resp <= mem_rdata;
      if (state == RESP) last <= owner;
    end
  end
  assign busy        = state == BUSY && !proc_reset;
  assign resp_st     = state == RESP && !proc_reset;
  assign mem_read    = busy & ~wr & ~mem_ready;
  assign mem_write   = busy & wr & ~mem_ready;
  assign mem_addr    = proc_reset ? '0 : addr;
  assign mem_wdata   = proc_reset ? '0 : wdata;
  assign i_mem_ready = resp_st & ~owner;
  assign d_mem_ready = resp_st & owner;
  assign i_mem_rdata = i_mem_ready ? resp : '0;
  assign d_mem_rdata = d_mem_ready ? resp : '0;
endmodule
